// File: rtl/riscv_pkg.sv
// Shared RV32 core types and constants.
// Divider op encodings and FSM states live here with XLEN.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  function automatic logic [XLEN-1:0] neg_if(
    input logic [XLEN-1:0] v,
    input logic            s
  );
    return s ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring radix-2 RV32M divider (EX stage).
// One quotient bit per cycle; special cases bypass CALC.
module div_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  div_op_t         op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] dq_q, dq_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  div_op_t         op_q, op_d;
  logic            nq_q, nq_d;
  logic            nr_q, nr_d;

  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;
  logic            sgn;
  logic            is_rem_q;

  // dq_q holds the dividend; quotient bits shift in from the LSB.
  assign rem_sh   = {rem_q, dq_q[XLEN-1]};
  assign diff     = rem_sh[XLEN-1:0] - dvs_q;
  assign ge       = rem_sh >= {1'b0, dvs_q};
  assign sgn      = (op == DIV) || (op == REM);
  assign is_rem_q = (op_q == REM) || (op_q == REMU);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    op_d    = op_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d = op;
          if (operand_b == '0) begin
            res_d   = (op == REM || op == REMU) ? operand_a : '1;
            state_d = DONE;
          end else if (sgn && operand_a == MIN_NEG &&
                       operand_b == '1) begin
            res_d   = (op == REM) ? '0 : MIN_NEG;
            state_d = DONE;
          end else begin
            nq_d    = sgn & (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
            nr_d    = sgn & operand_a[XLEN-1];
            dq_d    = neg_if(operand_a, sgn & operand_a[XLEN-1]);
            dvs_d   = neg_if(operand_b, sgn & operand_b[XLEN-1]);
            rem_d   = '0;
            cnt_d   = CNT_W'(XLEN-1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dq_d  = {dq_q[XLEN-2:0], ge};
        rem_d = ge ? diff : rem_sh[XLEN-1:0];
        if (cnt_q == '0) begin
          state_d = DONE;
          res_d   = is_rem_q ? neg_if(rem_d, nr_q)
                             : neg_if(dq_d, nq_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      op_q    <= DIV;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      op_q    <= op_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
    end
  end

  assign busy   = state_q != IDLE;
  assign done   = (state_q == DONE) && !flush;
  assign result = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit.
// Cycle 0 is the cycle start is held high.
module tb_div_unit;
  import riscv_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  div_op_t         op = DIV;
  logic [XLEN-1:0] operand_a = '0;
  logic [XLEN-1:0] operand_b = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int n_vec = 0;
  int n_bad = 0;

  div_unit dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .flush(flush),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy(busy),
    .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input div_op_t o,
                    input logic [XLEN-1:0] a,
                    input logic [XLEN-1:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    tick();
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic run(input string tag,
                     input div_op_t o,
                     input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b,
                     input int lat,
                     input logic [XLEN-1:0] exp);
    go(o, a, b);
    for (int c = 1; c <= lat; c++) begin
      chk({tag, " busy"}, XLEN'(busy), 1);
      chk({tag, " done"}, XLEN'(done), XLEN'(c == lat));
      if (c == lat) chk({tag, " result"}, result, exp);
      tick();
    end
    chk({tag, " idle busy"}, XLEN'(busy), 0);
    chk({tag, " idle done"}, XLEN'(done), 0);
    chk({tag, " held"}, result, exp);
  endtask

  initial begin
    tick();
    tick();
    chk("rst busy", XLEN'(busy), 0);
    chk("rst done", XLEN'(done), 0);
    chk("rst result", result, 0);
    rst = 1'b0;
    tick();

    run("div 100/7", DIV, 100, 7, 33, 14);
    run("rem -7/2", REM, 32'hFFFF_FFF9, 2, 33, 32'hFFFF_FFFF);
    run("div -7/2", DIV, 32'hFFFF_FFF9, 2, 33, 32'hFFFF_FFFD);
    run("divu big/2", DIVU, 32'hFFFF_FFF9, 2, 33, 32'h7FFF_FFFC);
    run("div 20/-3", DIV, 20, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFA);
    run("rem 20/-3", REM, 20, 32'hFFFF_FFFD, 33, 2);
    run("divu 5/0", DIVU, 5, 0, 1, 32'hFFFF_FFFF);
    run("remu 5/0", REMU, 5, 0, 1, 5);
    run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1,
        32'h8000_0000);
    run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);

    // flush at cycle 10; old result (0) must survive
    go(DIV, 100, 7);
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    chk("flush no done", XLEN'(done), 0);
    tick();
    flush = 1'b0;
    chk("flush busy", XLEN'(busy), 0);
    chk("flush done", XLEN'(done), 0);
    chk("flush result", result, 0);
    for (int c = 0; c < 30; c++) begin
      chk("flush quiet", XLEN'(done), 0);
      tick();
    end
    run("remu 10/3", REMU, 10, 3, 33, 1);

    // flush with start in IDLE: not accepted
    start = 1'b1;
    flush = 1'b1;
    op = DIVU;
    operand_a = 9;
    operand_b = 0;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("flush+start busy", XLEN'(busy), 0);
    chk("flush+start done", XLEN'(done), 0);

    // extra starts at cycles 5 and 33 are ignored
    go(DIV, 200, 7);
    for (int c = 1; c <= 33; c++) begin
      start     = (c == 5 || c == 33);
      op        = DIVU;
      operand_a = 9;
      operand_b = 0;
      chk("xs busy", XLEN'(busy), 1);
      chk("xs done", XLEN'(done), XLEN'(c == 33));
      if (c == 33) chk("xs result", result, 28);
      tick();
    end
    start = 1'b0;
    chk("xs busy after", XLEN'(busy), 0);
    chk("xs result held", result, 28);

    // reset at cycle 20 of a second op
    go(REMU, 10, 3);
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst busy", XLEN'(busy), 0);
    chk("mid rst done", XLEN'(done), 0);
    chk("mid rst result", result, 0);
    for (int c = 0; c < 20; c++) begin
      chk("mid rst quiet", XLEN'(done), 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
